// File: rtl/viterbi_channel_injector.sv
// Channel error injector between convolutional encoder and Viterbi decoder.
// Seeded Galois LFSR drives random/burst triggers; counters cover one bounded window.
module viterbi_channel_injector #(
    parameter int          W         = 2,
    parameter int          N         = 3,
    parameter int          BURST_LEN = 4,
    parameter int          WINDOW    = 256,
    parameter logic [31:0] SEED      = 32'hACE12345
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic [1:0]   mode_i,
    input  logic [W-1:0] mask_i,
    input  logic         enable_i,
    input  logic [W-1:0] sym_i,
    output logic         valid_o,
    output logic [W-1:0] sym_o,
    output logic [W-1:0] err_mask_o,
    output logic [15:0]  inj_ct_o,
    output logic [15:0]  bit_err_ct_o,
    output logic [15:0]  word_ct_o,
    output logic         window_done_o
);

    localparam int          PW   = $clog2(W + 1);
    localparam int          BW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [15:0] WIN  = 16'(WINDOW);
    // Left-shift Galois taps for x^32+x^22+x^2+x+1
    localparam logic [31:0] TAPS = 32'h0040_0007;

    typedef enum logic {StIdle, StBurst} state_t;

    state_t         r_state;
    logic [BW-1:0]  r_burst_ct;
    logic [31:0]    r_lfsr;
    logic           r_valid;
    logic [W-1:0]   r_sym;
    logic [W-1:0]   r_mask;
    logic [15:0]    r_inj_ct;
    logic [15:0]    r_bit_ct;
    logic [15:0]    r_word_ct;

    logic           w_trig;
    logic           w_active;
    logic [W-1:0]   w_m;
    logic [31:0]    w_lfsr_next;
    logic [PW-1:0]  w_pop;
    logic [16:0]    w_inj_sum;
    logic [16:0]    w_bit_sum;

    function automatic logic [PW-1:0] popcount(input logic [W-1:0] v);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) c = c + PW'(v[i]);
        return c;
    endfunction

    assign w_trig      = &r_lfsr[N-1:0];
    assign w_active    = (r_word_ct < WIN);
    assign w_lfsr_next = {r_lfsr[30:0], 1'b0} ^ ({32{r_lfsr[31]}} & TAPS);

    always_comb begin
        w_m = '0;
        if (w_active) begin
            unique case (mode_i)
                2'b00: w_m = '0;
                2'b01: w_m = w_trig ? mask_i : '0;
                2'b10: w_m = (r_state == StBurst || w_trig) ? mask_i : '0;
                2'b11: w_m = (&r_word_ct[N-1:0]) ? mask_i : '0;
                default: w_m = '0;
            endcase
        end
    end

    assign w_pop     = popcount(w_m);
    assign w_inj_sum = {1'b0, r_inj_ct} + 17'(w_m != '0);
    assign w_bit_sum = {1'b0, r_bit_ct} + 17'(w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_burst_ct <= '0;
            r_lfsr     <= SEED;
            r_valid    <= 1'b0;
            r_sym      <= '0;
            r_mask     <= '0;
            r_inj_ct   <= '0;
            r_bit_ct   <= '0;
            r_word_ct  <= '0;
        end else if (clr_i) begin
            r_state    <= StIdle;
            r_burst_ct <= '0;
            r_lfsr     <= SEED;
            r_valid    <= 1'b0;
            r_sym      <= '0;
            r_mask     <= '0;
            r_inj_ct   <= '0;
            r_bit_ct   <= '0;
            r_word_ct  <= '0;
        end else begin
            r_valid <= enable_i;
            if (enable_i) begin
                r_sym  <= sym_i ^ w_m;
                r_mask <= w_m;
                r_lfsr <= w_lfsr_next;
                if (w_active) begin
                    r_word_ct <= r_word_ct + 16'd1;
                    r_inj_ct  <= w_inj_sum[16] ? 16'hFFFF : w_inj_sum[15:0];
                    r_bit_ct  <= w_bit_sum[16] ? 16'hFFFF : w_bit_sum[15:0];
                end
                // Leaving burst mode or running out of window aborts any burst in flight
                if (!w_active || mode_i != 2'b10) begin
                    r_state <= StIdle;
                end else begin
                    unique case (r_state)
                        StIdle: begin
                            if (w_trig) begin
                                r_burst_ct <= BW'(BURST_LEN - 1);
                                if (BURST_LEN > 1) r_state <= StBurst;
                            end
                        end
                        StBurst: begin
                            r_burst_ct <= r_burst_ct - BW'(1);
                            if (r_burst_ct == BW'(1)) r_state <= StIdle;
                        end
                        default: r_state <= StIdle;
                    endcase
                end
            end
        end
    end

    assign valid_o       = r_valid;
    assign sym_o         = r_sym;
    assign err_mask_o    = r_mask;
    assign inj_ct_o      = r_inj_ct;
    assign bit_err_ct_o  = r_bit_ct;
    assign word_ct_o     = r_word_ct;
    assign window_done_o = (r_word_ct == WIN);

endmodule

// File: tb/tb_viterbi_channel_injector.sv
// Scoreboard bench for viterbi_channel_injector: driver pushes expected symbol/mask,
// a negedge monitor pops and compares; counters are checked at test boundaries.
module tb_viterbi_channel_injector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clr_i = 1'b0;
    logic [1:0] mode_i = 2'b00;
    logic [1:0] mask_i = 2'b00;
    logic       enable_i = 1'b0;
    logic [1:0] sym_i = 2'b00;
    logic       valid_o;
    logic [1:0] sym_o;
    logic [1:0] err_mask_o;
    logic [15:0] inj_ct_o;
    logic [15:0] bit_err_ct_o;
    logic [15:0] word_ct_o;
    logic       window_done_o;

    viterbi_channel_injector #(
        .W(2), .N(3), .BURST_LEN(4), .WINDOW(256), .SEED(32'hACE12345)
    ) dut (
        .clk(clk), .rst(rst), .clr_i(clr_i), .mode_i(mode_i), .mask_i(mask_i),
        .enable_i(enable_i), .sym_i(sym_i), .valid_o(valid_o), .sym_o(sym_o),
        .err_mask_o(err_mask_o), .inj_ct_o(inj_ct_o), .bit_err_ct_o(bit_err_ct_o),
        .word_ct_o(word_ct_o), .window_done_o(window_done_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [3:0] exp_q[$];
    logic [3:0] last_exp = 4'h0;

    // Reference channel model
    logic [31:0] m_lfsr;
    int m_word, m_left, m_inj, m_bits;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 32'hACE12345;
        m_word = 0; m_left = 0; m_inj = 0; m_bits = 0;
    endtask

    task automatic model_step(input logic [1:0] md, input logic [1:0] mk,
                              output logic [1:0] em);
        logic t;
        logic msb;
        t  = (m_lfsr[2:0] == 3'b111);
        em = 2'b00;
        if (m_word < 256) begin
            case (md)
                2'd1: if (t) em = mk;
                2'd2: begin
                    if (m_left > 0) begin em = mk; m_left--; end
                    else if (t) begin em = mk; m_left = 3; end
                end
                2'd3: if (m_word % 8 == 7) em = mk;
                default: em = 2'b00;
            endcase
            if (md != 2'd2) m_left = 0;
            m_word++;
            if (em != 2'b00) m_inj++;
            m_bits += int'(em[0]) + int'(em[1]);
        end else begin
            m_left = 0;
        end
        msb    = m_lfsr[31];
        m_lfsr = m_lfsr << 1;
        if (msb) m_lfsr = m_lfsr ^ 32'h0040_0007;
    endtask

    task automatic send(input logic en, input logic [1:0] s, input logic [1:0] md,
                        input logic [1:0] mk);
        logic [1:0] em;
        @(posedge clk); #1;
        enable_i = en; sym_i = s; mode_i = md; mask_i = mk;
        if (en) begin
            model_step(md, mk, em);
            exp_q.push_back({s ^ em, em});
        end
    endtask

    task automatic chk_cts(input string tag, input int inj, input int bits, input int word);
        send(1'b0, 2'b00, mode_i, mask_i);
        @(negedge clk);
        chk({tag, "_inj"}, int'(inj_ct_o), inj);
        chk({tag, "_bits"}, int'(bit_err_ct_o), bits);
        chk({tag, "_word"}, int'(word_ct_o), word);
        chk({tag, "_done"}, int'(window_done_o), int'(word == 256));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(valid_o), 0);
        chk({tag, "_sym"}, int'(sym_o), 0);
        chk({tag, "_mask"}, int'(err_mask_o), 0);
        chk({tag, "_inj"}, int'(inj_ct_o), 0);
        chk({tag, "_bits"}, int'(bit_err_ct_o), 0);
        chk({tag, "_word"}, int'(word_ct_o), 0);
        chk({tag, "_done"}, int'(window_done_o), 0);
    endtask

    task automatic do_clr(input string tag);
        send(1'b0, 2'b00, mode_i, mask_i);
        @(posedge clk); #1;
        clr_i = 1'b1; enable_i = 1'b1; sym_i = 2'b11;
        @(posedge clk); #1;
        clr_i = 1'b0; enable_i = 1'b0;
        model_reset();
        last_exp = 4'h0;
        @(negedge clk);
        chk_zero(tag);
    endtask

    task automatic do_async_rst(input string tag);
        send(1'b0, 2'b00, mode_i, mask_i);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        exp_q.delete();
        model_reset();
        last_exp = 4'h0;
        chk_zero(tag);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Monitor: pops on valid, checks hold behaviour when idle
    always @(negedge clk) begin
        if (rst) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    last_exp = exp_q.pop_front();
                    chk("sym_o", int'(sym_o), int'(last_exp[3:2]));
                    chk("err_mask_o", int'(err_mask_o), int'(last_exp[1:0]));
                end
            end else begin
                chk("hold", int'({sym_o, err_mask_o}), int'(last_exp));
            end
        end
    end

    function automatic logic [1:0] det_sym(input int i);
        return 2'((i * 7 + i / 3) % 4);
    endfunction

    initial begin
        bit found;
        model_reset();
        #12;
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: mode off, window boundary at 255/256
        for (int i = 0; i < 255; i++) send(1'b1, 2'($urandom_range(0, 3)), 2'd0, 2'b11);
        chk_cts("t1a", 0, 0, 255);
        for (int i = 0; i < 45; i++) send(1'b1, 2'($urandom_range(0, 3)), 2'd0, 2'b11);
        chk_cts("t1b", 0, 0, 256);

        // 2: periodic, single bit
        do_clr("clr2");
        for (int i = 0; i < 256; i++) send(1'b1, 2'($urandom_range(0, 3)), 2'd3, 2'b10);
        chk_cts("t2", 32, 32, 256);

        // 3: periodic, both bits, enable toggling
        do_clr("clr3");
        for (int i = 0; i < 512; i++) send(i % 2 == 0, 2'($urandom_range(0, 3)), 2'd3, 2'b11);
        chk_cts("t3", 32, 64, 256);

        // 4: bursts over a full window, plus a few past the end
        do_clr("clr4");
        for (int i = 0; i < 260; i++) send(1'b1, 2'($urandom_range(0, 3)), 2'd2, 2'b01);
        chk_cts("t4", m_inj, m_bits, 256);
        chk("t4_inj_nonzero", int'(inj_ct_o != 0), 1);

        // 5: abort a burst on its 2nd symbol, then resume burst mode
        do_clr("clr5");
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            send(1'b1, 2'($urandom_range(0, 3)), 2'd2, 2'b11);
            if (m_left == 3) found = 1'b1;
        end
        chk("t5_burst_found", int'(found), 1);
        for (int i = 0; i < 10; i++) send(1'b1, 2'($urandom_range(0, 3)), 2'd0, 2'b11);
        for (int i = 0; i < 40; i++) send(1'b1, 2'($urandom_range(0, 3)), 2'd2, 2'b11);
        chk_cts("t5", m_inj, m_bits, m_word);

        // 6: async reset at word 100, replay; then same with clr
        do_clr("clr6");
        for (int i = 0; i < 100; i++) send(1'b1, det_sym(i), 2'd2, 2'b10);
        do_async_rst("t6_rst");
        for (int i = 0; i < 120; i++) send(1'b1, det_sym(i), 2'd2, 2'b10);
        chk_cts("t6a", m_inj, m_bits, 120);
        do_clr("clr6b");
        for (int i = 0; i < 100; i++) send(1'b1, det_sym(i), 2'd2, 2'b10);
        do_clr("t6_clr");
        for (int i = 0; i < 120; i++) send(1'b1, det_sym(i), 2'd2, 2'b10);
        chk_cts("t6b", m_inj, m_bits, 120);

        send(1'b0, 2'b00, 2'd0, 2'b00);
        send(1'b0, 2'b00, 2'd0, 2'b00);
        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_channel_injector.md
Name: viterbi_channel_injector

Overview:
Parametrised channel model between the convolutional encoder and the Viterbi decoder.
- Corrupts W-bit code symbols under one of four run-time modes: off, random, burst, periodic.
- Counts injected symbols and flipped bits inside a bounded measurement window.
- Registered, deterministic (seeded LFSR), so decoder BER experiments are repeatable in simulation and synthesis.

Parameters:
W, 2, code symbol width (bits per encoder output)
N, 3, rate exponent; random trigger probability 2^-N, periodic interval 2^N symbols
BURST_LEN, 4, consecutive symbols corrupted per burst (>=1)
WINDOW, 256, number of symbols in the measurement/injection window
SEED, 32'hACE12345, LFSR reset/clear value (must be nonzero)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-low reset
clr_i  input  1  synchronous clear of counters, LFSR, FSM; priority over enable_i
mode_i  input  2  00 off, 01 random, 10 burst, 11 periodic
mask_i  input  W  bits XORed into a corrupted symbol
enable_i  input  1  sym_i valid this cycle
sym_i  input  W  clean encoder symbol
valid_o  output  1  sym_o valid (enable_i delayed 1 cycle)
sym_o  output  W  channel output symbol to decoder
err_mask_o  output  W  mask actually applied to sym_o (0 if clean)
inj_ct_o  output  16  symbols corrupted in window, saturating
bit_err_ct_o  output  16  bits flipped in window (popcount sum), saturating
word_ct_o  output  16  symbols seen, stops at WINDOW
window_done_o  output  1  sticky high once word_ct_o == WINDOW

Behaviour:
- Reset (rst low, async): all outputs 0. LFSR = SEED, FSM = IDLE, burst counter 0.
- clr_i high at clock edge: same state as reset. Outputs 0 next cycle. enable_i that cycle is ignored (valid_o=0 next cycle).
- Latency 1 cycle: on enable_i, next cycle sym_o = sym_i ^ m, err_mask_o = m, valid_o = 1. Otherwise valid_o = 0 and sym_o/err_mask_o hold their last values.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Advances only on enable_i cycles. Trigger T = (lfsr[N-1:0] == all ones), evaluated on the pre-advance value.
- Injection is allowed only while word_ct_o < WINDOW. At and after WINDOW, m = 0 and the counters freeze.
- m per mode, for an enabled symbol at index k = word_ct_o (pre-increment):
  - 00 off: m = 0.
  - 01 random: m = T ? mask_i : 0.
  - 10 burst: see FSM below.
  - 11 periodic: m = (k[N-1:0] == all ones) ? mask_i : 0.
- Burst FSM, states IDLE and BURST, advances only on enable_i:
  - IDLE & mode 10 & T: m = mask_i, burst counter = BURST_LEN-1; go to BURST if BURST_LEN > 1.
  - BURST: m = mask_i, counter decrements; at counter 0 (after this symbol) return to IDLE. T is ignored while in BURST.
  - mode_i != 10 in BURST: abort to IDLE, and m follows the new mode on that same cycle.
  - Window end during BURST: burst is clipped, return to IDLE.
- Counters update on each enabled symbol within the window:
  - word_ct_o += 1.
  - inj_ct_o += (m != 0).
  - bit_err_ct_o += popcount(m).
  - inj_ct_o and bit_err_ct_o saturate at 16'hFFFF; word_ct_o stops at WINDOW.
- mask_i = 0 with a trigger: counts as no injection (m = 0).
- mode_i and mask_i are sampled every enabled cycle. Changes take effect on the next enabled symbol, without restarting the window.
- Reset mid-burst or mid-window: everything returns to reset values immediately; no partial counts are retained.

Test Plan:
1. mode 00, 300 symbols of random sym_i -> sym_o == sym_i delayed 1 cycle. inj_ct_o = 0, word_ct_o = 256, window_done_o = 1 after the 256th symbol.
2. mode 11, N=3, mask_i = 2'b10, 256 contiguous symbols -> indices 7,15,...,255 corrupted in bit 1 only. inj_ct_o = 32, bit_err_ct_o = 32.
3. mode 11, mask_i = 2'b11, enable_i toggling every other cycle -> valid_o follows 1 cycle late. inj_ct_o = 32, bit_err_ct_o = 64 after 256 enabled symbols.
4. mode 10, BURST_LEN=4, SEED default -> every corrupted run is exactly 4 symbols long (except a final run clipped at 256). inj_ct_o == 4 × bursts started (last clipped). Runs match a reference LFSR model.
5. mode 10; switch mode_i to 00 on the 2nd symbol of a burst -> that symbol and all later ones are clean. Switch back to 10 -> the next burst starts only on a new trigger.
6. Assert rst low mid-burst at word 100 -> all outputs 0 asynchronously. After release, an identical stimulus reproduces the same corruption sequence from word 0. Repeat using clr_i.
